// File: rtl/reg_write_arbiter_pkg.sv
// Shared types, defaults and helpers for the register-bank write-port arbiter.
//   DW_DEF / NREG_DEF : default data width and register count
//   AW_DEF            : register address width derived from NREG_DEF
//   MAX_REQ / IDXW    : largest supported requester count and its index width
//   arb_state_t       : IDLE (no owner) / LOCKED (owner holds the port)
//   pick_t            : result of a rotate-priority search (valid + index)
//   find_first_from   : first set bit of a vector scanning upward from a start
//                       position, wrapping modulo the live vector length
package reg_write_arbiter_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned NREG_DEF = 8;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned IDXW     = $clog2(MAX_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } pick_t;

  // Scan positions start, start+1, ... wrapping at n; only the first n bits of
  // vec are live. The wrap is a subtract rather than a modulo so the loop
  // unrolls into a plain priority chain.
  function automatic pick_t find_first_from(input logic [MAX_REQ-1:0] vec,
                                            input int unsigned        n,
                                            input int unsigned        start);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = start + k;
      if (j >= n) begin
        j = j - n;
      end
      if (!r.valid && (k < n) && (j < MAX_REQ) && vec[IDXW'(j)]) begin
        r.valid = 1'b1;
        r.idx   = IDXW'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   req         : request vector, one bit per requester
//   ptr         : highest-priority position for this cycle
//   win_c       : one-hot winner (all zero when nothing requests)
//   win_idx_c   : binary index of the winner
//   win_valid_c : at least one request present
module reg_write_arbiter_rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_c,
  output logic [PW-1:0]   win_idx_c,
  output logic            win_valid_c
);

  pick_t pick;

  // Search from ptr, then expand the binary winner back to one-hot.
  always_comb begin
    pick        = find_first_from(MAX_REQ'(req), NREQ, 32'(ptr));
    win_valid_c = pick.valid;
    win_idx_c   = PW'(pick.idx);
    win_c       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      win_c[i] = pick.valid && (pick.idx == IDXW'(i));
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for a bank of load-enabled registers.
// Picks at most one write per cycle, drives the shared data bus and a one-hot
// load enable, and acknowledges the winner. A requester asserting req_lock
// keeps the port for back-to-back writes until it drops req or req_lock.
//   CLK, reset : clock and synchronous active-high reset
//   req        : per-requester write request, held until granted
//   req_lock   : per-requester request to keep ownership after a grant
//   req_addr   : packed target register index, requester i at [i*AW +: AW]
//   req_data   : packed write data, requester i at [i*DW +: DW]
//   gnt        : registered one-hot acknowledge of the accepted write
//   reg_load   : registered one-hot load enable into the register bank
//   reg_d      : registered shared data bus (holds last value when idle)
//   busy       : registered, high while a locked owner holds the port
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [NREG-1:0]  reg_load,
  output logic [DW-1:0]    reg_d,
  output logic             busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;

  logic [NREQ-1:0] pick_win;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

  logic            hold;
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREQ-1:0] gnt_n;
  logic [NREG-1:0] load_n;
  logic [DW-1:0]   d_n;

  // Rotate-priority search used whenever no locked owner keeps the port.
  reg_write_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req         (req),
    .ptr         (ptr),
    .win_c       (pick_win),
    .win_idx_c   (pick_idx),
    .win_valid_c (pick_valid)
  );

  // Next state, winner selection and next output values.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    win_valid = 1'b0;
    win_idx   = owner;
    gnt_n     = '0;
    load_n    = '0;
    d_n       = reg_d;

    // Owner keeps the port only while it asks for both the write and the lock;
    // otherwise the same cycle falls through to a normal round-robin pick, and
    // ptr already points past the old owner.
    hold = (state == LOCKED) && req[owner] && req_lock[owner];

    if (hold) begin
      win_valid = 1'b1;
      win_idx   = owner;
      for (int unsigned i = 0; i < NREQ; i++) begin
        gnt_n[i] = (owner == PW'(i));
      end
    end else begin
      state_n = IDLE;
      gnt_n   = pick_win;
      if (pick_valid) begin
        win_valid = 1'b1;
        win_idx   = pick_idx;
        ptr_n     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        if (req_lock[pick_idx]) begin
          state_n = LOCKED;
          owner_n = pick_idx;
        end
      end
    end

    win_addr = req_addr[32'(win_idx) * AW +: AW];
    win_data = req_data[32'(win_idx) * DW +: DW];

    for (int unsigned i = 0; i < NREG; i++) begin
      load_n[i] = win_valid && (win_addr == AW'(i));
    end

    if (win_valid) begin
      d_n = win_data;
    end
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      reg_load <= '0;
      reg_d    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      gnt      <= gnt_n;
      reg_load <= load_n;
      reg_d    <= d_n;
      busy     <= (state_n == LOCKED);
    end
  end

endmodule
